sparce_sasa_table: RTL and testbench

SPARCE_SASA_TABLE -- requirements
Module: sparce_sasa_table

---
 rtl/sparce_sasa_table.sv | 115 +++++++++++
 tb/tb_sparce_sasa_table.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sparce_sasa_table.sv
// Skip-ahead (SASA) table: config writes stage a PC then commit an entry; every
// cycle the fetch PC is matched against all valid entries and the hit is registered.
module sparce_sasa_table #(
  parameter int          SASA_ENTRIES = 16,
  parameter logic [31:0] SASA_ADDR    = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  output logic [31:0] preceding_pc,
  output logic [4:0]  sasa_rs1,
  output logic [4:0]  sasa_rs2,
  output logic [1:0]  condition,
  output logic [15:0] insts_to_skip,
  output logic        sasa_hit
);
  localparam int IW = (SASA_ENTRIES > 1) ? $clog2(SASA_ENTRIES) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  cond;
    logic [15:0] skip;
  } sasa_entry_t;

  logic [SASA_ENTRIES-1:0]               valid_q, valid_d;
  sasa_entry_t [SASA_ENTRIES-1:0]        ent_q, ent_d;
  logic                                  staged_q, staged_d;
  logic [31:0]                           stage_pc_q, stage_pc_d;
  logic [IW-1:0]                         ptr_q, ptr_d;
  sasa_entry_t                           out_q, out_d;
  logic                                  hit_q, hit_d;

  logic [SASA_ENTRIES-1:0] look_hit, cmt_hit;
  sasa_entry_t             new_ent;
  logic                    wr_stage, wr_commit, wr_clear;
  logic                    unused_data;

  assign unused_data = ^sasa_data[15:12];

  // Per-entry comparators: one against the fetch PC, one against the staged PC.
  for (genvar g = 0; g < SASA_ENTRIES; g++) begin : g_ent
    assign look_hit[g] = valid_q[g] && (ent_q[g].pc == pc);
    assign cmt_hit[g]  = valid_q[g] && (ent_q[g].pc == stage_pc_q);
  end

  assign wr_stage  = sasa_wen && (sasa_addr == SASA_ADDR);
  assign wr_commit = sasa_wen && (sasa_addr == SASA_ADDR + 32'd4) && staged_q;
  assign wr_clear  = sasa_wen && (sasa_addr == SASA_ADDR + 32'd8);
  assign new_ent   = '{pc: stage_pc_q, rs1: sasa_data[4:0], rs2: sasa_data[9:5],
                       cond: sasa_data[11:10], skip: sasa_data[31:16]};

  always_comb begin
    valid_d    = valid_q;
    ent_d      = ent_q;
    staged_d   = staged_q;
    stage_pc_d = stage_pc_q;
    ptr_d      = ptr_q;
    hit_d      = |look_hit;
    out_d      = '0;
    // Lookup reads the pre-write table; descending scan leaves the lowest index.
    for (int i = SASA_ENTRIES - 1; i >= 0; i--)
      if (look_hit[i]) out_d = ent_q[i];

    if (wr_stage) begin
      staged_d   = 1'b1;
      stage_pc_d = sasa_data;
    end else if (wr_commit) begin
      staged_d = 1'b0;
      if (|cmt_hit) begin
        for (int i = 0; i < SASA_ENTRIES; i++)
          if (cmt_hit[i]) ent_d[i] = new_ent;
      end else begin
        ent_d[ptr_q]   = new_ent;
        valid_d[ptr_q] = 1'b1;
        ptr_d          = ptr_q + 1'b1;
      end
    end else if (wr_clear) begin
      valid_d  = '0;
      staged_d = 1'b0;
      ptr_d    = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q    <= '0;
      ent_q      <= '0;
      staged_q   <= 1'b0;
      stage_pc_q <= '0;
      ptr_q      <= '0;
      out_q      <= '0;
      hit_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      ent_q      <= ent_d;
      staged_q   <= staged_d;
      stage_pc_q <= stage_pc_d;
      ptr_q      <= ptr_d;
      out_q      <= out_d;
      hit_q      <= hit_d;
    end
  end

  assign preceding_pc  = out_q.pc;
  assign sasa_rs1      = out_q.rs1;
  assign sasa_rs2      = out_q.rs2;
  assign condition     = out_q.cond;
  assign insts_to_skip = out_q.skip;
  assign sasa_hit      = hit_q;
endmodule

// File: tb/tb_sparce_sasa_table.sv
// Directed + randomized bench for sparce_sasa_table against a table model
// holding raw committed words, decoded only when a lookup is predicted.
module tb_sparce_sasa_table;
  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc = '0, sasa_addr = '0, sasa_data = '0;
  logic        sasa_wen = 1'b0;
  logic [31:0] preceding_pc;
  logic [4:0]  sasa_rs1, sasa_rs2;
  logic [1:0]  condition;
  logic [15:0] insts_to_skip;
  logic        sasa_hit;

  sparce_sasa_table #(.SASA_ENTRIES(N), .SASA_ADDR(BASE)) dut (
    .CLK(CLK), .RST(RST), .pc(pc), .sasa_wen(sasa_wen), .sasa_addr(sasa_addr),
    .sasa_data(sasa_data), .preceding_pc(preceding_pc), .sasa_rs1(sasa_rs1),
    .sasa_rs2(sasa_rs2), .condition(condition), .insts_to_skip(insts_to_skip),
    .sasa_hit(sasa_hit)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  bit          m_valid[N];
  logic [31:0] m_pc[N];
  logic [31:0] m_word[N];
  int          m_ptr;
  bit          m_staged;
  logic [31:0] m_spc;

  function automatic logic [60:0] decode(logic [31:0] p, logic [31:0] w);
    return {1'b1, p, w[4:0], w[9:5], w[11:10], w[31:16]};
  endfunction

  function automatic logic [60:0] model_lookup(logic [31:0] p);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_pc[i] == p) return decode(m_pc[i], m_word[i]);
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr = 0; m_staged = 1'b0; m_spc = '0;
  endtask

  task automatic model_write(logic [31:0] a, logic [31:0] d);
    int idx;
    if (a == BASE) begin
      m_staged = 1'b1; m_spc = d;
    end else if (a == BASE + 32'd4 && m_staged) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (idx < 0 && m_valid[i] && m_pc[i] == m_spc) idx = i;
      if (idx < 0) begin
        idx = m_ptr; m_ptr = (m_ptr + 1) % N;
      end
      m_valid[idx] = 1'b1; m_pc[idx] = m_spc; m_word[idx] = d;
      m_staged = 1'b0;
    end else if (a == BASE + 32'd8) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_staged = 1'b0; m_ptr = 0;
    end
  endtask

  function automatic logic [60:0] dut_out();
    return {sasa_hit, preceding_pc, sasa_rs1, sasa_rs2, condition, insts_to_skip};
  endfunction

  task automatic check(string tag, logic [60:0] exp);
    logic [60:0] got;
    got = dut_out();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict from the pre-write model, then sample after the edge.
  task automatic step(bit wen, logic [31:0] a, logic [31:0] d, logic [31:0] p, string tag);
    logic [60:0] exp;
    @(negedge CLK);
    sasa_wen = wen; sasa_addr = a; sasa_data = d; pc = p;
    exp = model_lookup(p);
    if (wen) model_write(a, d);
    @(posedge CLK); #1;
    check(tag, exp);
  endtask

  task automatic commit(logic [31:0] p, logic [31:0] w, string tag);
    step(1'b1, BASE, p, 32'h0, tag);
    step(1'b1, BASE + 32'd4, w, 32'h0, tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check("reset_outputs", '0);
    RST = 1'b0;

    // Commit with nothing staged must not create an entry (pc 0 would hit it).
    step(1'b1, BASE + 32'd4, 32'h0005_0443, 32'h0, "r030_commit");
    step(1'b0, 32'h0, 32'h0, 32'h0, "r030_look");
    check("r030_zero", '0);

    commit(32'h200, 32'h0005_0443, "r029_cfg");
    step(1'b0, 32'h0, 32'h0, 32'h200, "r029_look");
    check("r029_const", {1'b1, 32'h200, 5'd3, 5'd2, 2'b01, 16'd5});

    // Re-commit: same entry updated, pointer must stay at 1.
    commit(32'h200, 32'h0009_0443, "r032_cfg");
    step(1'b0, 32'h0, 32'h0, 32'h200, "r032_look");
    check("r032_const", {1'b1, 32'h200, 5'd3, 5'd2, 2'b01, 16'd9});
    for (int k = 0; k < N - 1; k++) commit(32'h4000 + 32'(k * 4), $urandom, "r032_fill");
    step(1'b0, 32'h0, 32'h0, 32'h200, "r032_ptr");
    check("r032_ptr_const", {1'b1, 32'h200, 5'd3, 5'd2, 2'b01, 16'd9});

    // Clear in the same cycle as a hit: that hit registers, next cycle misses.
    step(1'b1, BASE + 32'd8, $urandom, 32'h200, "r033_same");
    check("r033_same_const", {1'b1, 32'h200, 5'd3, 5'd2, 2'b01, 16'd9});
    step(1'b0, 32'h0, 32'h0, 32'h200, "r033_next");
    check("r033_next_const", '0);

    // 17 commits into 16 entries: first evicted, pointer wraps to 1.
    for (int k = 0; k < 17; k++) commit(32'h3000 + 32'(k * 4), 32'h0001_0000 * 32'(k + 1), "r031_cfg");
    for (int k = 0; k < 17; k++) step(1'b0, 32'h0, 32'h0, 32'h3000 + 32'(k * 4), "r031_look");
    step(1'b0, 32'h0, 32'h0, 32'h3000, "r031_first");
    check("r031_first_miss", '0);
    step(1'b0, 32'h0, 32'h0, 32'h3040, "r031_last");
    check("r031_last_hit", {1'b1, 32'h3040, 5'd0, 5'd0, 2'b00, 16'd17});
    commit(32'h3100, 32'h0033_0000, "r031_ptr_cfg");
    step(1'b0, 32'h0, 32'h0, 32'h3004, "r031_ptr_evict");
    check("r031_ptr_evict_const", '0);
    step(1'b0, 32'h0, 32'h0, 32'h3008, "r031_ptr_keep");
    check("r031_ptr_keep_const", {1'b1, 32'h3008, 5'd0, 5'd0, 2'b00, 16'd3});

    // Reset between stage and commit word; outputs must clear asynchronously.
    step(1'b1, BASE, 32'h500, 32'h3008, "r034_stage");
    @(negedge CLK);
    sasa_wen = 1'b0; #2;
    RST = 1'b1; model_reset(); #1;
    check("r034_async_rst", '0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    step(1'b1, BASE + 32'd4, 32'h0005_0443, 32'h500, "r034_commit");
    step(1'b0, 32'h0, 32'h0, 32'h500, "r034_look");
    check("r034_look_const", '0);
    step(1'b0, 32'h0, 32'h0, 32'h0, "r034_look0");
    check("r034_look0_const", '0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] p, a, d;
      bit          w;
      int          op;
      p  = 32'h100 + 32'($urandom_range(0, 23) * 4);
      op = $urandom_range(0, 19);
      w = 1'b1; d = $urandom; a = BASE;
      if (op < 6)       begin a = BASE; d = 32'h100 + 32'($urandom_range(0, 23) * 4); end
      else if (op < 12) a = BASE + 32'd4;
      else if (op == 12) a = BASE + 32'd8;
      else if (op < 15) a = BASE + 32'($urandom_range(1, 3)) + ($urandom_range(0, 1) ? 32'd12 : 32'd0);
      else if (op < 17) a = $urandom;
      else if (op == 17) begin w = 1'b0; a = BASE + 32'd4; end
      else              w = 1'b0;
      step(w, a, d, p, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
